fir_sample_feeder: RTL

- Producer end of the FIR sample interface.
- Accepts 3-bit signed samples from an upstream valid/ready source and buffers them in a small FIFO.
- Derives the 300 kHz sample strobe from the 12 MHz clock (divide by 40).
- On each strobe, presents one sample plus an accumulate enable to the transposed FIR MAC; drives its sample input and enable inputs directly.

---
 rtl/fir_pkg.sv | 11 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/fir_sample_feeder.sv | 84 ++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants and the signed sample type for the FIR datapath.
package fir_pkg;

  localparam int FIR_IN_W         = 3;
  localparam int FIR_COEFF_W      = 16;
  localparam int FIR_NUM_TAPS     = 10;
  localparam int FIR_CLK_DIV_300K = 40;

  typedef logic signed [FIR_IN_W-1:0] fir_sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with an occupancy counter; push-when-full and
// pop-when-empty are ignored so the pointers never run past each other.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int DW    = FIR_IN_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever read after
  // it has been written, and leaving it out keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Producer end of the FIR sample interface: FIFO-buffers upstream samples and
// presents one per 300 kHz strobe. Define FIR_FEEDER_UNDERRUN_STALL_EN to stall
// (no accumulate, hold sample) instead of inserting zero on an empty strobe.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int CLK_DIV = FIR_CLK_DIV_300K,
  parameter int DEPTH   = 4,
  parameter int DW      = FIR_IN_W
) (
  input  logic                       iClk_12M,
  input  logic                       iRst,
  input  logic                       iInValid,
  input  logic signed [DW-1:0]       iInData,
  output logic                       oInReady,
  input  logic                       iClrUnderrun,
  output logic                       oEnSample_300k,
  output logic                       oEnAcc,
  output logic signed [DW-1:0]       oFirIn,
  output logic [$clog2(DEPTH+1)-1:0] oLevel,
  output logic                       oUnderrun
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_head;

  assign tick     = (div_cnt == CW'(CLK_DIV - 1));
  assign oInReady = !fifo_full;

  always_ff @(posedge iClk_12M) begin
    if (iRst)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + CW'(1);
  end

  // The tick pops the head; a push in the same edge lands behind it, so an
  // empty-FIFO tick never sees the sample arriving alongside it.
  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (iClk_12M),
    .rst       (iRst),
    .push      (iInValid && oInReady),
    .push_data (iInData),
    .pop       (tick),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (oLevel)
  );

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      oEnSample_300k <= 1'b0;
      oEnAcc         <= 1'b0;
      oFirIn         <= '0;
      oUnderrun      <= 1'b0;
    end else begin
      oEnSample_300k <= tick;
      oEnAcc         <= 1'b0;
      if (tick && !fifo_empty) begin
        oFirIn <= fifo_head;
        oEnAcc <= 1'b1;
      end else if (tick) begin
`ifdef FIR_FEEDER_UNDERRUN_STALL_EN
        oEnAcc <= 1'b0;
`else
        oFirIn <= '0;
        oEnAcc <= 1'b1;
`endif
      end
      // A new underrun outranks a clear arriving on the same edge.
      if (tick && fifo_empty) oUnderrun <= 1'b1;
      else if (iClrUnderrun)  oUnderrun <= 1'b0;
    end
  end

endmodule
